main_mem_lat: RTL and testbench

Parametrised, latency-accurate main-memory model for the cache/memory hierarchy. Replaces the single-bus chip-select/inout memory with a valid/ready request channel and a separate response channel. Width, depth, address range and access latency are configurable. It serves one outstanding request at a time and flags out-of-range accesses.

---
 rtl/main_mem_lat_pkg.sv | 19 +
 rtl/main_mem_lat_array.sv | 54 +++++
 rtl/main_mem_lat.sv | 133 +++++++++++++
 tb/tb_main_mem_lat.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_lat_pkg.sv
// main_mem_pkg: FSM state encoding and default geometry for the main-memory latency model.
`default_nettype none

package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int C_DATA_WIDTH    = 128;
    localparam int C_ADDR_WIDTH    = 32;
    localparam int C_MEM_ADDR_BITS = 25;
    localparam int C_LATENCY       = 5;

endpackage

`default_nettype wire

// File: rtl/main_mem_lat_array.sv
// main_mem_array: line storage with synchronous read; byte-strobed write under MAIN_MEM_WSTRB_EN.
`default_nettype none

module main_mem_array #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_BITS  = 25
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_we,
    input  logic                      i_re,
    input  logic [ADDR_BITS-1:0]      i_addr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
    output logic [DATA_WIDTH-1:0]     o_rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

`ifdef MAIN_MEM_WSTRB_EN
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end
`else
    logic w_unused_wstrb;
    assign w_unused_wstrb = ^i_wstrb;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end
`endif

    // Read register only loads on reads, so it holds across write responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/main_mem_lat.sv
// main_mem_lat: latency-accurate main memory, one outstanding request, out-of-range flagging.
// Optional byte strobes enabled by defining MAIN_MEM_WSTRB_EN.
`default_nettype none

module main_mem_lat
    import main_mem_pkg::*;
#(
    parameter int DATA_WIDTH    = C_DATA_WIDTH,
    parameter int ADDR_WIDTH    = C_ADDR_WIDTH,
    parameter int MEM_ADDR_BITS = C_MEM_ADDR_BITS,
    parameter int LATENCY       = C_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_we;
    logic [MEM_ADDR_BITS-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic                      r_oor;
    logic                      r_err;
    logic                      r_rd_oor;

    logic                      w_req_oor;
    logic                      w_accept;
    logic                      w_access;
    logic                      w_src_we;
    logic                      w_src_oor;
    logic [MEM_ADDR_BITS-1:0]  w_src_addr;
    logic [DATA_WIDTH-1:0]     w_src_wdata;
    logic [DATA_WIDTH/8-1:0]   w_src_wstrb;
    logic [DATA_WIDTH-1:0]     w_arr_rdata;

    if (MEM_ADDR_BITS < ADDR_WIDTH) begin : g_range
        assign w_req_oor = |req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
    end else begin : g_full
        assign w_req_oor = 1'b0;
    end

    assign w_accept = (r_state == IDLE) && req_valid;
    // With LATENCY=1 the array is accessed on the accept edge from the live request.
    assign w_access = ((r_state == BUSY) && (r_cnt == CNT_W'(1)))
                   || (w_accept && (LATENCY == 1));

    assign w_src_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_src_oor   = (r_state == IDLE) ? w_req_oor : r_oor;
    assign w_src_addr  = (r_state == IDLE) ? req_addr[MEM_ADDR_BITS-1:0] : r_addr;
    assign w_src_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_src_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;

    main_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_access && w_src_we && !w_src_oor),
        .i_re    (w_access && !w_src_we),
        .i_addr  (w_src_addr),
        .i_wdata (w_src_wdata),
        .i_wstrb (w_src_wstrb),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_oor    <= 1'b0;
            r_err    <= 1'b0;
            r_rd_oor <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr[MEM_ADDR_BITS-1:0];
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        r_oor   <= w_req_oor;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_err   <= w_req_oor;
                            if (!req_we) r_rd_oor <= w_req_oor;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= RESP;
                        r_err   <= r_oor;
                        if (!r_we) r_rd_oor <= r_oor;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = r_err;
    assign rsp_rdata = r_rd_oor ? '0 : w_arr_rdata;

endmodule

`default_nettype wire

// File: tb/tb_main_mem_lat.sv
// tb_main_mem_lat: directed scoreboard bench for main_mem_lat at default geometry.
`default_nettype none

module tb_main_mem_lat;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wstrb;
    logic         rsp_valid;
    logic [127:0] rsp_rdata;
    logic         rsp_err;

    typedef struct {
        logic         rd;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [127:0] last_rd  = '0;

    always #5 clk = ~clk;

    main_mem_lat u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        req_wstrb = 16'($urandom);
    endtask

    // Pops the scoreboard entry and compares the response present this cycle.
    task automatic check_rsp(input string tag, input int lat, input int exp_lat);
        exp_t e;
        check({tag, "_valid"}, 128'(rsp_valid), 128'(1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 128'(0), 128'(1));
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_err"}, 128'(rsp_err), 128'(e.err));
        if (e.rd) begin
            check({tag, "_rdata"}, rsp_rdata, e.data);
            last_rd = e.data;
        end else begin
            check({tag, "_rdata_hold"}, rsp_rdata, last_rd);
        end
    endtask

    // Latency counted in cycles from the acceptance cycle (valid && ready) to the response cycle.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [127:0] wd, input logic [15:0] ws,
                          input logic [127:0] exp_d, input logic exp_e);
        int n;
        int lat;
        sb.push_back('{rd: !we, data: exp_d, err: exp_e});
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check({tag, "_ready_timeout"}, 128'(0), 128'(1));
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        scramble_inputs();
        while (!rsp_valid && lat < 20) begin
            check({tag, "_busy_ready"}, 128'(req_ready), 128'(0));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_rsp(tag, lat, 5);
        check({tag, "_resp_ready"}, 128'(req_ready), 128'(0));
        @(negedge clk);
        check({tag, "_pulse_end"}, 128'(rsp_valid), 128'(0));
        check({tag, "_idle_ready"}, 128'(req_ready), 128'(1));
    endtask

    initial begin
        int cyc;
        int lat;
        logic saw_rsp;
        logic [127:0] strb_exp;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '1;
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(req_ready), 128'(1));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rdata", rsp_rdata, 128'(0));
        check("rst_err", 128'(rsp_err), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        do_req("wr1", 1'b1, 32'h1, 128'hFFFFFFFFFFFFF, '1, '0, 1'b0);
        do_req("rd1", 1'b0, 32'h1, '0, '1, 128'hFFFFFFFFFFFFF, 1'b0);
        do_req("wr_top", 1'b1, 32'h1FFFFFF, 128'h555, '1, '0, 1'b0);
        do_req("rd_top", 1'b0, 32'h1FFFFFF, '0, '1, 128'h555, 1'b0);
        do_req("wr_oor", 1'b1, 32'hFFFFFFF, 128'h1234, '1, '0, 1'b1);
        do_req("rd_oor", 1'b0, 32'hFFFFFFF, '0, '1, '0, 1'b1);
        do_req("rd_top2", 1'b0, 32'h1FFFFFF, '0, '1, 128'h555, 1'b0);
        do_req("rd_unwr", 1'b0, 32'h40, '0, '1, '0, 1'b0);

        // Back-to-back with req_valid held high: accepts must be 6 cycles apart.
        sb.push_back('{rd: 1'b0, data: '0, err: 1'b0});
        sb.push_back('{rd: 1'b1, data: 128'hBEEF, err: 1'b0});
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 128'hBEEF;
        req_wstrb = '1;
        @(posedge clk);
        @(negedge clk);
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_wdata = '0;
        cyc = 1;
        lat = 1;
        saw_rsp = 1'b0;
        while (!req_ready && cyc < 20) begin
            if (rsp_valid) begin
                check_rsp("b2b_wr", lat, 5);
                saw_rsp = 1'b1;
            end
            check("b2b_busy_ready", 128'(req_ready), 128'(0));
            @(posedge clk);
            cyc++;
            lat++;
            @(negedge clk);
        end
        check("b2b_wr_seen", 128'(saw_rsp), 128'(1));
        @(posedge clk);
        check("b2b_gap", 128'(cyc), 128'(6));
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        scramble_inputs();
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_rsp("b2b_rd", lat, 5);
        @(negedge clk);

        // Reset two cycles after acceptance drops the pending write.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h2;
        req_wdata = 128'h76;
        req_wstrb = '1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 128'(req_ready), 128'(1));
        rst_n   = 1'b1;
        last_rd = '0;
        saw_rsp = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("mid_rst_no_rsp", 128'(saw_rsp), 128'(0));
        check("mid_rst_ready2", 128'(req_ready), 128'(1));
        do_req("rd_after_rst", 1'b0, 32'h2, '0, '1, '0, 1'b0);

`ifdef MAIN_MEM_WSTRB_EN
        strb_exp = {{15{8'hAA}}, 8'h00};
`else
        strb_exp = '0;
`endif
        do_req("wr_aa", 1'b1, 32'h3, {16{8'hAA}}, '1, '0, 1'b0);
        do_req("wr_strb", 1'b1, 32'h3, '0, 16'h0001, '0, 1'b0);
        do_req("rd_strb", 1'b0, 32'h3, '0, '1, strb_exp, 1'b0);

        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
